fifo_ctrl_512x8b: RTL and testbench

Byte-wide first-word-fall-through FIFO controller that owns the write and read ports of the 512x8 dual-port RAM. Producers push bytes with a valid/ready handshake; the controller writes them into the RAM, prefetches them through the RAM's one-cycle registered read into a two-entry output stage, and presents them to a consumer with a second valid/ready handshake. It sits directly in front of and behind the RAM and is the standard buffer for byte streams such as UART RX/TX and the program loader.

---
 rtl/fifo_ctrl_512x8b_if.sv | 20 ++
 rtl/fifo_ctrl_512x8b.sv | 103 ++++++++++
 tb/tb_fifo_ctrl_512x8b.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_512x8b_if.sv
// Producer/consumer handshake bundle for fifo_ctrl_512x8b.
// slave = the FIFO controller, master = the producer/consumer side.
interface fifo_ctrl_512x8b_if;
  logic       i_push_valid;
  logic [7:0] i_push_data;
  logic       o_push_ready;
  logic       o_pop_valid;
  logic [7:0] o_pop_data;
  logic       i_pop_ready;

  modport slave (
    input  i_push_valid, i_push_data, i_pop_ready,
    output o_push_ready, o_pop_valid, o_pop_data
  );

  modport master (
    output i_push_valid, i_push_data, i_pop_ready,
    input  o_push_ready, o_pop_valid, o_pop_data
  );
endinterface

// File: rtl/fifo_ctrl_512x8b.sv
// FWFT byte FIFO controller in front of a 512x8 RAM with a 1-cycle registered read
// and a two-entry head/skid output stage. Optional level counter: FIFO_LEVEL_EN.
module fifo_ctrl_512x8b #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  fifo_ctrl_512x8b_if.slave     bus,
  output logic                  o_mem_we,
  output logic [DEPTH_LOG2-1:0] o_mem_waddr,
  output logic [7:0]            o_mem_wdata,
  output logic [DEPTH_LOG2-1:0] o_mem_raddr,
  input  logic [7:0]            i_mem_rdata,
  output logic [9:0]            o_level
);
  localparam int PW = DEPTH_LOG2 + 1;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          r_rd_pend;
  logic [1:0]    r_stage_cnt;
  logic [7:0]    r_head;
  logic [7:0]    r_skid;

  logic [PW-1:0] w_ram_cnt;
  logic          w_ram_full;
  logic          w_ram_empty;
  logic          w_push_fire;
  logic          w_pop_fire;
  logic [2:0]    w_occ;
  logic          w_issue;
  logic [1:0]    w_cnt_after_pop;
  logic          w_load_head;
  logic          w_load_skid;
  logic          w_shift;

  // Occupancy never exceeds 2^DEPTH_LOG2, so the top bit alone flags full.
  assign w_ram_cnt   = r_wptr - r_rptr;
  assign w_ram_full  = w_ram_cnt[DEPTH_LOG2];
  assign w_ram_empty = (r_wptr == r_rptr);

  assign w_push_fire = bus.i_push_valid && !w_ram_full;
  assign w_pop_fire  = bus.i_pop_ready && (r_stage_cnt != 2'd0);

  // Stage slots already committed (held + in flight) once this cycle's pop leaves.
  assign w_occ   = {1'b0, r_stage_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop_fire};
  assign w_issue = !w_ram_empty && (w_occ < 3'd2);

  assign w_cnt_after_pop = r_stage_cnt - {1'b0, w_pop_fire};
  assign w_load_head     = r_rd_pend && (w_cnt_after_pop == 2'd0);
  assign w_load_skid     = r_rd_pend && (w_cnt_after_pop != 2'd0);
  assign w_shift         = w_pop_fire && (r_stage_cnt == 2'd2);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_rd_pend   <= 1'b0;
      r_stage_cnt <= 2'd0;
      r_head      <= 8'h00;
    end else begin
      if (w_push_fire) r_wptr <= r_wptr + 1'b1;
      if (w_issue)     r_rptr <= r_rptr + 1'b1;
      r_rd_pend   <= w_issue;
      r_stage_cnt <= r_stage_cnt - {1'b0, w_pop_fire} + {1'b0, r_rd_pend};
      if (w_load_head)  r_head <= i_mem_rdata;
      else if (w_shift) r_head <= r_skid;
    end
  end

  // Skid contents are only meaningful while stage_cnt says so; no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_load_skid) r_skid <= i_mem_rdata;
  end

  assign bus.o_push_ready = !w_ram_full;
  assign bus.o_pop_valid  = (r_stage_cnt != 2'd0);
  assign bus.o_pop_data   = r_head;

  assign o_mem_we    = w_push_fire;
  assign o_mem_waddr = r_wptr[DEPTH_LOG2-1:0];
  assign o_mem_wdata = bus.i_push_data;
  assign o_mem_raddr = r_rptr[DEPTH_LOG2-1:0];

`ifdef FIFO_LEVEL_EN
  localparam logic [9:0] CAP = 10'((2 ** DEPTH_LOG2) + 2);
  logic [9:0] r_level;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_level <= 10'd0;
    end else if (w_push_fire && !w_pop_fire && (r_level != CAP)) begin
      r_level <= r_level + 10'd1;
    end else if (w_pop_fire && !w_push_fire) begin
      r_level <= r_level - 10'd1;
    end
  end

  assign o_level = r_level;
`else
  assign o_level = 10'd0;
`endif
endmodule

// File: tb/tb_fifo_ctrl_512x8b.sv
// Randomised self-checking bench for fifo_ctrl_512x8b; reference is a byte queue
// plus a behavioural 512x8 registered-read RAM.
module tb_fifo_ctrl_512x8b;
  logic       i_clk = 1'b0;
  logic       i_nrst;
  logic       o_mem_we;
  logic [8:0] o_mem_waddr;
  logic [7:0] o_mem_wdata;
  logic [8:0] o_mem_raddr;
  logic [7:0] i_mem_rdata;
  logic [9:0] o_level;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [7:0] ram [512];

  always #5 i_clk = ~i_clk;

  fifo_ctrl_512x8b_if bus();

  fifo_ctrl_512x8b #(.DEPTH_LOG2(9)) dut (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .bus         (bus),
    .o_mem_we    (o_mem_we),
    .o_mem_waddr (o_mem_waddr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_raddr (o_mem_raddr),
    .i_mem_rdata (i_mem_rdata),
    .o_level     (o_level)
  );

  always @(posedge i_clk) begin
    if (o_mem_we) ram[o_mem_waddr] <= o_mem_wdata;
    i_mem_rdata <= ram[o_mem_raddr];
  end

  function automatic int exp_level();
`ifdef FIFO_LEVEL_EN
    return q.size();
`else
    return 0;
`endif
  endfunction

  // One clock: drive inputs, observe handshakes mid-cycle, update the queue model.
  task automatic cycle(input logic pv, input logic [7:0] pd, input logic pr,
                       output logic pushed, output logic popped,
                       output logic [7:0] got, output logic [7:0] exp_d);
    bus.i_push_valid = pv;
    bus.i_push_data  = pd;
    bus.i_pop_ready  = pr;
    @(negedge i_clk);
    pushed = pv && bus.o_push_ready;
    popped = pr && bus.o_pop_valid;
    got    = bus.o_pop_data;
    exp_d  = 8'h00;
    if (popped) begin
      if (q.size() > 0) exp_d = q.pop_front();
      else              exp_d = ~got;
    end
    if (pushed) q.push_back(pd);
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_push_valid = 1'b0;
    bus.i_push_data  = 8'h00;
    bus.i_pop_ready  = 1'b0;
    i_nrst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    q.delete();
    checks++; if (bus.o_pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid got %0b want 0", bus.o_pop_valid); end
    checks++; if (bus.o_pop_data !== 8'h00) begin errors++; $display("FAIL reset_pop_data got %h want 00", bus.o_pop_data); end
    checks++; if (bus.o_push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready got %0b want 1", bus.o_push_ready); end
    checks++; if (o_mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b want 0", o_mem_we); end
    checks++; if (o_mem_waddr !== 9'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", o_mem_waddr); end
    checks++; if (o_mem_raddr !== 9'd0) begin errors++; $display("FAIL reset_raddr got %0d want 0", o_mem_raddr); end
    checks++; if (o_level !== 10'd0) begin errors++; $display("FAIL reset_level got %0d want 0", o_level); end
    i_nrst = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_single();
    logic pu, po;
    logic [7:0] g, e;
    cycle(1'b1, 8'hA5, 1'b1, pu, po, g, e);
    checks++; if (pu !== 1'b1) begin errors++; $display("FAIL single_push got %0b want 1", pu); end
    checks++; if (int'(o_level) != exp_level()) begin errors++; $display("FAIL single_level1 got %0d want %0d", o_level, exp_level()); end
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (bus.o_pop_valid !== (k == 3)) begin
        errors++; $display("FAIL single_latency cycle %0d got %0b want %0b", k, bus.o_pop_valid, (k == 3));
      end
      if (k < 3) cycle(1'b0, 8'h00, 1'b1, pu, po, g, e);
    end
    checks++; if (bus.o_pop_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", bus.o_pop_data); end
    cycle(1'b0, 8'h00, 1'b1, pu, po, g, e);
    checks++; if (po !== 1'b1 || g !== e) begin errors++; $display("FAIL single_pop got %0b/%h want 1/%h", po, g, e); end
    checks++; if (bus.o_pop_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %0b want 0", bus.o_pop_valid); end
    checks++; if (int'(o_level) != exp_level()) begin errors++; $display("FAIL single_level0 got %0d want %0d", o_level, exp_level()); end
  endtask

  task automatic fill_up(input logic [7:0] base, output int acc);
    logic pu, po;
    logic [7:0] g, e, d;
    acc = 0;
    for (int c = 0; c < 700 && acc < 514; c++) begin
      d = base + acc[7:0];
      cycle(1'b1, d, 1'b0, pu, po, g, e);
      if (pu) acc++;
    end
  endtask

  task automatic drain(input string tag, output int n, output logic [7:0] last);
    logic pu, po;
    logic [7:0] g, e;
    n = 0;
    last = 8'h00;
    for (int c = 0; c < 800 && (q.size() > 0 || bus.o_pop_valid); c++) begin
      cycle(1'b0, 8'h00, 1'b1, pu, po, g, e);
      if (po) begin
        n++;
        last = g;
        checks++;
        if (g !== e) begin errors++; $display("FAIL %s_order pop %0d got %h want %h", tag, n, g, e); end
      end
    end
  endtask

  task automatic test_fill();
    int acc, n;
    logic pu, po;
    logic [7:0] g, e;
    fill_up(8'h00, acc);
    checks++; if (acc != 514) begin errors++; $display("FAIL fill_accepted got %0d want 514", acc); end
    checks++; if (bus.o_push_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0b want 0", bus.o_push_ready); end
    checks++; if (int'(o_level) != exp_level()) begin errors++; $display("FAIL fill_level got %0d want %0d", o_level, exp_level()); end
    cycle(1'b1, 8'hEE, 1'b0, pu, po, g, e);
    checks++; if (pu !== 1'b0) begin errors++; $display("FAIL fill_515th got %0b want 0", pu); end
    drain("fill", n, g);
    checks++; if (n != 514) begin errors++; $display("FAIL fill_popcount got %0d want 514", n); end
    checks++; if (g !== 8'h01) begin errors++; $display("FAIL fill_lastbyte got %h want 01", g); end
  endtask

  task automatic test_full_simul();
    int acc, n;
    logic pu, po;
    logic [7:0] g, e;
    fill_up(8'h40, acc);
    checks++; if (acc != 514) begin errors++; $display("FAIL simul_fill got %0d want 514", acc); end
    cycle(1'b1, 8'hC3, 1'b1, pu, po, g, e);
    checks++; if (pu !== 1'b0) begin errors++; $display("FAIL simul_push_refused got %0b want 0", pu); end
    checks++; if (po !== 1'b1 || g !== 8'h40) begin errors++; $display("FAIL simul_pop got %0b/%h want 1/40", po, g); end
    checks++; if (bus.o_push_ready !== 1'b1) begin errors++; $display("FAIL simul_ready_rise got %0b want 1", bus.o_push_ready); end
    cycle(1'b1, 8'hC3, 1'b0, pu, po, g, e);
    checks++; if (pu !== 1'b1) begin errors++; $display("FAIL simul_push_next got %0b want 1", pu); end
    drain("simul", n, g);
    checks++; if (n != 514) begin errors++; $display("FAIL simul_popcount got %0d want 514", n); end
    checks++; if (g !== 8'hC3) begin errors++; $display("FAIL simul_lastbyte got %h want c3", g); end
  endtask

  task automatic test_stream();
    int npush = 0, npop = 0, stalls = 0, wraps_w = 0, wraps_r = 0;
    logic started = 1'b0;
    logic pu, po;
    logic [7:0] g, e, d;
    logic [8:0] pw, pr9;
    for (int c = 0; c < 2200 && npop < 2000; c++) begin
      pw = o_mem_waddr;
      pr9 = o_mem_raddr;
      d = npush[7:0];
      cycle(npush < 2000, d, 1'b1, pu, po, g, e);
      if (npush < 2000 && !pu) stalls++;
      if (pu) npush++;
      if (pw == 9'd511 && o_mem_waddr == 9'd0) wraps_w++;
      if (pr9 == 9'd511 && o_mem_raddr == 9'd0) wraps_r++;
      if (po) begin
        started = 1'b1;
        checks++;
        if (g !== e || g !== npop[7:0]) begin errors++; $display("FAIL stream_data pop %0d got %h want %h", npop, g, npop[7:0]); end
        npop++;
      end else if (started) begin
        stalls++;
      end
    end
    checks++; if (npop != 2000) begin errors++; $display("FAIL stream_count got %0d want 2000", npop); end
    checks++; if (stalls != 0) begin errors++; $display("FAIL stream_stalls got %0d want 0", stalls); end
    checks++; if (wraps_w < 3 || wraps_r < 3) begin errors++; $display("FAIL stream_wraps got w%0d r%0d want >=3", wraps_w, wraps_r); end
  endtask

  task automatic test_random();
    int n, lv;
    logic pu, po;
    logic [7:0] g, e;
    for (int c = 0; c < 10000; c++) begin
      cycle(1'($urandom % 2), 8'($urandom), 1'($urandom % 2), pu, po, g, e);
      lv = q.size();
      if (po) begin
        checks++;
        if (g !== e) begin errors++; $display("FAIL rand_data cycle %0d got %h want %h", c, g, e); end
      end
      checks++;
      if (o_mem_we && !bus.o_push_ready) begin errors++; $display("FAIL rand_we_noready cycle %0d got we=1 want 0", c); end
      checks++;
      if ((lv < 512 && bus.o_push_ready !== 1'b1) || (lv >= 514 && bus.o_push_ready !== 1'b0)) begin
        errors++; $display("FAIL rand_ready cycle %0d held %0d got %0b", c, lv, bus.o_push_ready);
      end
      checks++;
      if (lv == 0 && bus.o_pop_valid !== 1'b0) begin errors++; $display("FAIL rand_empty_valid cycle %0d got 1 want 0", c); end
      checks++;
      if (((int'(o_mem_waddr) - int'(o_mem_raddr)) & 511) > lv) begin
        errors++; $display("FAIL rand_raddr cycle %0d raddr %0d waddr %0d held %0d", c, o_mem_raddr, o_mem_waddr, lv);
      end
      checks++;
      if (int'(o_level) != exp_level()) begin errors++; $display("FAIL rand_level cycle %0d got %0d want %0d", c, o_level, exp_level()); end
    end
    drain("rand", n, g);
    checks++; if (q.size() != 0 || bus.o_pop_valid !== 1'b0) begin errors++; $display("FAIL rand_drain got %0d left want 0", q.size()); end
  endtask

  task automatic test_midreset();
    logic pu, po, seen;
    logic [7:0] g, e;
    int acc = 0;
    for (int c = 0; c < 150 && acc < 100; c++) begin
      cycle(1'b1, 8'($urandom), 1'b0, pu, po, g, e);
      if (pu) acc++;
    end
    checks++; if (acc != 100 || bus.o_pop_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got %0d/%0b want 100/1", acc, bus.o_pop_valid); end
    #2;
    i_nrst = 1'b0;
    #1;
    q.delete();
    checks++; if (bus.o_pop_valid !== 1'b0) begin errors++; $display("FAIL mid_pop_valid got %0b want 0", bus.o_pop_valid); end
    checks++; if (bus.o_push_ready !== 1'b1) begin errors++; $display("FAIL mid_push_ready got %0b want 1", bus.o_push_ready); end
    checks++; if (o_level !== 10'd0) begin errors++; $display("FAIL mid_level got %0d want 0", o_level); end
    @(posedge i_clk);
    #1;
    i_nrst = 1'b1;
    cycle(1'b1, 8'h3C, 1'b0, pu, po, g, e);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle(1'b0, 8'h00, 1'b1, pu, po, g, e);
      if (po) seen = 1'b1;
    end
    checks++; if (!seen || g !== 8'h3C) begin errors++; $display("FAIL mid_first_byte got %0b/%h want 1/3c", seen, g); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_simul();
    test_stream();
    test_random();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
